// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin scheduler time-sharing one registered adder among NREQ requesters
module add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH:0]          sum,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     last, last_n;
  logic [WIDTH-1:0]  op_a, op_a_n, op_b, op_b_n;
  logic [NREQ-1:0]   grant_n, done_n;
  logic [WIDTH:0]    sum_n;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = a_in[i*WIDTH +: WIDTH];
      b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end
  end

  // Search starts just after the last winner and wraps, so the first hit is the RR choice.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    op_a_n  = op_a;
    op_b_n  = op_b;
    grant_n = grant;
    done_n  = '0;
    sum_n   = sum;
    case (state)
      IDLE: begin
        if (win_found) begin
          op_a_n  = a_arr[win_idx];
          op_b_n  = b_arr[win_idx];
          grant_n = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          cnt_n   = CNT_LOAD;
          last_n  = win_idx;
          state_n = CALC;
        end
      end
      CALC: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          sum_n   = {1'b0, op_a} + {1'b0, op_b};
          done_n  = grant;
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= LAST_RST;
      op_a  <= '0;
      op_b  <= '0;
      grant <= '0;
      done  <= '0;
      sum   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      grant <= grant_n;
      done  <= done_n;
      sum   <= sum_n;
    end
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed bench for add_arbiter with an operation-level reference model
module tb_add_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       grant, done;
  logic [WIDTH:0]        sum;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .done(done), .sum(sum), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an operation occupies LAT grant cycles, then one done cycle publishes the sum.
  logic [NREQ-1:0] exp_grant, exp_done;
  logic [WIDTH:0]  exp_sum;
  logic            exp_busy;
  int              m_last, m_left, m_win, m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_grant = '0; exp_done = '0; exp_sum = '0; exp_busy = 1'b0;
      m_last = NREQ - 1; m_left = 0; m_win = 0; m_a = 0; m_b = 0;
    end else begin
      exp_done = '0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_grant = '0;
          exp_busy  = 1'b0;
          exp_done  = NREQ'(1) << m_win;
          exp_sum   = (WIDTH+1)'(m_a + m_b);
        end
      end else if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req[(m_last + k) % NREQ]) begin
            m_win = (m_last + k) % NREQ;
            break;
          end
        end
        m_a = int'(a_in[m_win*WIDTH +: WIDTH]);
        m_b = int'(b_in[m_win*WIDTH +: WIDTH]);
        m_last = m_win;
        m_left = LAT;
        exp_grant = NREQ'(1) << m_win;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("grant", 32'(grant), 32'(exp_grant));
    check("done", 32'(done), 32'(exp_done));
    check("sum", 32'(sum), 32'(exp_sum));
    check("busy", 32'(busy), 32'(exp_busy));
    check("grant_done_overlap", 32'(grant & done), 32'd0);
    check("onehot", {30'd0, $onehot0(grant), $onehot0(done)}, 32'd3);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    step(2);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // single op
    set_op(1, 8'd10, 8'd20); req = 4'b0010;
    step(1); check("single_grant0", 32'(grant), 32'h2); check("single_busy", 32'(busy), 32'd1);
    req = '0;
    step(1); check("single_grant1", 32'(grant), 32'h2);
    step(1); check("single_done", 32'(done), 32'h2); check("single_sum", 32'(sum), 32'd30);
    check("single_idle", 32'(busy), 32'd0);
    step(1); check("single_done_clr", 32'(done), 32'd0);

    // carry, plus operand change after grant
    set_op(0, 8'd255, 8'd255); req = 4'b0001;
    step(1); req = '0; set_op(0, 8'd77, 8'd1);
    step(2); check("carry_sum", 32'(sum), 32'h1FE); check("carry_done", 32'(done), 32'h1);
    set_op(0, 8'd0, 8'd0); req = 4'b0001;
    step(1); req = '0;
    step(2); check("zero_sum", 32'(sum), 32'd0);
    step(1);

    // contention 0 and 2 after reset
    do_reset();
    set_op(0, 8'd3, 8'd4); set_op(2, 8'd5, 8'd6); req = 4'b0101;
    step(1); check("cont_first", 32'(grant), 32'h1);
    step(3); check("cont_second", 32'(grant), 32'h4);
    req = '0;
    step(2); check("cont_sum", 32'(sum), 32'd11);
    step(1);

    // all four continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'(10 * i));
    req = 4'b1111;
    step(1); check("rr_0", 32'(grant), 32'h1);
    step(3); check("rr_1", 32'(grant), 32'h2);
    step(3); check("rr_2", 32'(grant), 32'h4);
    step(3); check("rr_3", 32'(grant), 32'h8);
    step(3); check("rr_4", 32'(grant), 32'h1);
    req = '0;
    step(3);

    // back-to-back on requester 3
    set_op(3, 8'd1, 8'd2); req = 4'b1000;
    step(1); check("b2b_grant", 32'(grant), 32'h8);
    step(2); check("b2b_done0", 32'(done), 32'h8); check("b2b_sum0", 32'(sum), 32'd3);
    step(3); check("b2b_done1", 32'(done), 32'h8); check("b2b_sum1", 32'(sum), 32'd3);
    req = '0;
    step(3);

    // early drop
    set_op(2, 8'd100, 8'd50); req = 4'b0100;
    step(1); check("drop_grant", 32'(grant), 32'h4);
    step(1); req = '0;
    step(1); check("drop_done", 32'(done), 32'h4); check("drop_sum", 32'(sum), 32'd150);
    step(1);

    // reset mid-op
    set_op(0, 8'd5, 8'd6); set_op(1, 8'd7, 8'd8); req = 4'b0011;
    step(1); check("mid_grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_grant", 32'(grant), 32'd0); check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(1); check("post_rst_first", 32'(grant), 32'h1);
    step(3); check("post_rst_second", 32'(grant), 32'h2);
    req = '0;
    step(2); check("post_rst_sum", 32'(sum), 32'd15); check("post_rst_done", 32'(done), 32'h2);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
